// File: rtl/rv_pkg.sv
// Shared RISC-V control-transfer encodings and BTB types.
package rv_pkg;

    localparam logic [2:0] FMT_B    = 3'b011;
    localparam logic [2:0] FMT_J    = 3'b101;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        BTB_BR  = 1'b0,
        BTB_JMP = 1'b1
    } btb_kind_e;

    // Two-bit saturating direction counter step.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'd1;
        end
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump outcome and target computation.
module branch_resolve
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] i_pc,
    input  logic [2:0]      i_format,
    input  logic [2:0]      i_funct3,
    input  logic [6:0]      i_opcode,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_is_branch_c,
    output logic            o_is_jump_c,
    output logic            o_taken_c,
    output logic [XLEN-1:0] o_target_c,
    output logic [XLEN-1:0] o_next_pc_c
);

    logic [XLEN-1:0] w_seq_pc;
    logic [XLEN-1:0] w_rel_tgt;
    logic [XLEN-1:0] w_jalr_tgt;

    assign w_seq_pc   = i_pc + XLEN'(4);
    assign w_rel_tgt  = i_pc + i_imm;
    assign w_jalr_tgt = (i_a + i_imm) & ~XLEN'(1);

    // Decode the format, evaluate the branch condition and pick the target.
    // For branches the target is the taken target even when not taken, so the
    // BTB can be filled on a not-taken first execution.
    always_comb begin
        o_is_branch_c = 1'b0;
        o_is_jump_c   = 1'b0;
        o_taken_c     = 1'b0;
        o_target_c    = w_seq_pc;
        if (i_format == FMT_B) begin
            o_is_branch_c = 1'b1;
            o_target_c    = w_rel_tgt;
            case (i_funct3)
                F3_BEQ:  o_taken_c = (i_a == i_b);
                F3_BNE:  o_taken_c = (i_a != i_b);
                F3_BLT:  o_taken_c = ($signed(i_a) <  $signed(i_b));
                F3_BGE:  o_taken_c = ($signed(i_a) >= $signed(i_b));
                F3_BLTU: o_taken_c = (i_a <  i_b);
                F3_BGEU: o_taken_c = (i_a >= i_b);
                default: o_taken_c = 1'b0;
            endcase
        end else if (i_format == FMT_J) begin
            o_is_jump_c = 1'b1;
            o_taken_c   = 1'b1;
            o_target_c  = (i_opcode == OPC_JALR) ? w_jalr_tgt : w_rel_tgt;
        end
    end

    assign o_next_pc_c = o_taken_c ? o_target_c : w_seq_pc;

endmodule

// File: rtl/branch_predict_unit.sv
// BTB-based next-PC predictor with execute-stage resolution and redirect.
module branch_predict_unit
    import rv_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    output logic [XLEN-1:0]   if_pred_target,
    input  logic              ex_valid,
    input  logic              ex_flush,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [2:0]        ex_format,
    input  logic [2:0]        ex_funct3,
    input  logic [6:0]        ex_opcode,
    input  logic [XLEN-1:0]   ex_a,
    input  logic [XLEN-1:0]   ex_b,
    input  logic [XLEN-1:0]   ex_imm,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [CNT_W-1:0]  mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic            r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag   [ENTRIES];
    logic [XLEN-1:0] r_target [ENTRIES];
    btb_kind_e       r_kind   [ENTRIES];
    logic [1:0]      r_ctr    [ENTRIES];

    logic             r_redirect_valid;
    logic [XLEN-1:0]  r_redirect_pc;
    logic [CNT_W-1:0] r_mis_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [TAG_W-1:0] w_if_tag;
    logic             w_if_hit;
    logic [IDX_W-1:0] w_ex_idx;
    logic [TAG_W-1:0] w_ex_tag;
    logic             w_ex_hit;
    logic             w_ex_upd;
    logic             w_is_branch;
    logic             w_is_jump;
    logic             w_act_taken;
    logic [XLEN-1:0]  w_act_target;
    logic [XLEN-1:0]  w_act_next;
    logic             w_mispredict;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];

    // Fetch-side lookup; forced to a miss while reset is held.
    always_comb begin
        w_if_hit       = !rst && r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
        if_pred_taken  = w_if_hit && ((r_kind[w_if_idx] == BTB_JMP) || r_ctr[w_if_idx][1]);
        if_pred_target = if_pred_taken ? r_target[w_if_idx] : if_pc + XLEN'(4);
    end

    branch_resolve #(
        .XLEN (XLEN)
    ) u_resolve (
        .i_pc          (ex_pc),
        .i_format      (ex_format),
        .i_funct3      (ex_funct3),
        .i_opcode      (ex_opcode),
        .i_a           (ex_a),
        .i_b           (ex_b),
        .i_imm         (ex_imm),
        .o_is_branch_c (w_is_branch),
        .o_is_jump_c   (w_is_jump),
        .o_taken_c     (w_act_taken),
        .o_target_c    (w_act_target),
        .o_next_pc_c   (w_act_next)
    );

    // Compare the actual outcome with the prediction carried from fetch.
    always_comb begin
        w_ex_upd     = ex_valid && !ex_flush;
        w_ex_hit     = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
        w_mispredict = (w_act_taken != ex_pred_taken) ||
                       (w_act_taken && ex_pred_taken && (w_act_next != ex_pred_target));
    end

    // BTB update, registered redirect and saturating mispredict counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_mis_cnt        <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_kind[i]  <= BTB_BR;
                r_ctr[i]   <= 2'b01;
            end
        end else begin
            r_redirect_valid <= w_ex_upd && w_mispredict;
            if (w_ex_upd && w_mispredict) begin
                r_redirect_pc <= w_act_next;
                if (r_mis_cnt != {CNT_W{1'b1}}) begin
                    r_mis_cnt <= r_mis_cnt + CNT_W'(1);
                end
            end
            if (w_ex_upd) begin
                if (w_is_branch) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= w_act_target;
                    r_kind[w_ex_idx]   <= BTB_BR;
                    if (w_ex_hit) begin
                        r_ctr[w_ex_idx] <= ctr_step(r_ctr[w_ex_idx], w_act_taken);
                    end else begin
                        r_ctr[w_ex_idx] <= w_act_taken ? 2'b10 : 2'b01;
                    end
                end else if (w_is_jump) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= w_act_target;
                    r_kind[w_ex_idx]   <= BTB_JMP;
                    r_ctr[w_ex_idx]    <= 2'b11;
                end else if (w_ex_hit) begin
                    r_valid[w_ex_idx] <= 1'b0;
                end
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign mispredict_cnt = r_mis_cnt;

endmodule
